// File: rtl/mont_domain_exit_if.sv
// Operand/result bundle for mont_domain_exit: start/done request-response plus operands and result.
interface mont_domain_exit_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] M;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] Y;

    modport master (output start, X, M, input busy, done, err, Y);
    modport slave  (input start, X, M, output busy, done, err, Y);
endinterface

// File: rtl/mont_domain_exit.sv
// Montgomery domain exit: Y = X * 2^-N mod M via bit-serial radix-2 REDC and one final subtract.
// Latency N+1 cycles (1 cycle for even M); start is only taken in IDLE, requests while busy are dropped.
module mont_domain_exit #(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mont_domain_exit_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

    state_t        state_q, state_d;
    logic [N:0]    t_q, t_d;
    logic [N-1:0]  mr_q, mr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  y_q, y_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            mr_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            mr_q    <= mr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mr_d    = mr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.M[0]) begin
                        mr_d    = bus.M;
                        t_d     = {1'b0, bus.X};
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                // T stays below 2^N, so T + M always fits in N+1 bits before the halving.
                if (t_q[0]) t_d = (t_q + {1'b0, mr_q}) >> 1;
                else        t_d = t_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = FIN;
            end
            FIN: begin
                // T <= M here, so one subtraction lands in [0, M-1].
                if (t_q >= {1'b0, mr_q}) y_d = t_q[N-1:0] - mr_q;
                else                     y_d = t_q[N-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                y_d     = '0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.Y    = y_q;
endmodule
